// File: rtl/riscv_boot_ctrl.sv
// riscv_boot_ctrl
//   Boot/reset sequencer placed in front of riscv_pipeline_top. A program image arrives as a
//   valid/ready word stream, is written into instruction memory one word per accepted beat
//   (one cycle after the accept), and the core reset is then released after a short hold.
//   A start pulse in RUN reloads the image and re-resets the core.
//
//   Optional feature: define CHECKSUM_EN to require one trailer word after the data words.
//   The sum of all data words plus the trailer (mod 2**WORD_W) must be zero, otherwise the
//   block parks in ERR with boot_err high. Without CHECKSUM_EN, ERR is unreachable and
//   boot_err is tied low.
module riscv_boot_ctrl #(
    parameter int ADDR_W      = 10,
    parameter int WORD_W      = 32,
    parameter int HOLD_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W:0]   num_words,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [WORD_W-1:0] ld_data,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              core_reset_n,
    output logic              busy,
    output logic              boot_done,
    output logic              boot_err
);

    // Image length saturates at the memory capacity, so the write address never wraps.
    localparam logic [ADDR_W:0]   CAPACITY  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   REM_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] IDX_ONE   = ADDR_W'(1);
    localparam int                HCW       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HCW-1:0]    HOLD_LOAD = HCW'(HOLD_CYCLES - 1);
    localparam logic [HCW-1:0]    HOLD_ONE  = HCW'(1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_HOLD = 3'd2,
        ST_RUN  = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ADDR_W:0]   remaining_r;
    logic [ADDR_W-1:0] idx_r;
    logic [HCW-1:0]    hold_cnt_r;
    logic              accept_s;
    logic              start_ok_s;
    logic              data_beat_s;
    logic              write_s;
    logic [ADDR_W:0]   load_len_s;
`ifdef CHECKSUM_EN
    logic [WORD_W-1:0] sum_r;
    logic [WORD_W-1:0] sum_total_s;
`endif

    function automatic logic [ADDR_W:0] sat_len(input logic [ADDR_W:0] n);
        if (n > CAPACITY) begin
            return CAPACITY;
        end else begin
            return n;
        end
    endfunction

    // Handshake decode: which beats are accepted and whether an accepted beat is image data.
    always_comb begin
        accept_s   = ld_valid && ld_ready;
        start_ok_s = start && ((state_r == ST_IDLE) || (state_r == ST_RUN) || (state_r == ST_ERR));
        load_len_s = sat_len(num_words);
`ifdef CHECKSUM_EN
        // Once all data words are in, the next accepted beat is the trailer.
        data_beat_s = (remaining_r != {(ADDR_W + 1){1'b0}});
        sum_total_s = sum_r + ld_data;
`else
        data_beat_s = 1'b1;
`endif
        write_s = accept_s && data_beat_s;
    end

    // Next-state logic for the boot sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_RUN, ST_ERR: begin
                if (start) begin
`ifdef CHECKSUM_EN
                    // An empty image still carries a trailer, so always stream.
                    state_nxt_s = ST_LOAD;
`else
                    if (num_words == {(ADDR_W + 1){1'b0}}) begin
                        state_nxt_s = ST_HOLD;
                    end else begin
                        state_nxt_s = ST_LOAD;
                    end
`endif
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_LOAD: begin
                if (accept_s) begin
`ifdef CHECKSUM_EN
                    if (!data_beat_s) begin
                        if (sum_total_s == {WORD_W{1'b0}}) begin
                            state_nxt_s = ST_HOLD;
                        end else begin
                            state_nxt_s = ST_ERR;
                        end
                    end else begin
                        state_nxt_s = ST_LOAD;
                    end
`else
                    if (remaining_r == REM_ONE) begin
                        state_nxt_s = ST_HOLD;
                    end else begin
                        state_nxt_s = ST_LOAD;
                    end
`endif
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_r == {HCW{1'b0}}) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Load bookkeeping: words still expected, next write address, and the hold down-counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            remaining_r <= {(ADDR_W + 1){1'b0}};
            idx_r       <= {ADDR_W{1'b0}};
            hold_cnt_r  <= {HCW{1'b0}};
        end else begin
            if (start_ok_s) begin
                remaining_r <= load_len_s;
                idx_r       <= {ADDR_W{1'b0}};
            end else if (write_s) begin
                remaining_r <= remaining_r - REM_ONE;
                idx_r       <= idx_r + IDX_ONE;
            end
            if ((state_nxt_s == ST_HOLD) && (state_r != ST_HOLD)) begin
                hold_cnt_r <= HOLD_LOAD;
            end else if ((state_r == ST_HOLD) && (hold_cnt_r != {HCW{1'b0}})) begin
                hold_cnt_r <= hold_cnt_r - HOLD_ONE;
            end
        end
    end

`ifdef CHECKSUM_EN
    // Running sum of the data words; the trailer is added combinationally when it arrives.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_r <= {WORD_W{1'b0}};
        end else if (start_ok_s) begin
            sum_r <= {WORD_W{1'b0}};
        end else if (write_s) begin
            sum_r <= sum_r + ld_data;
        end
    end

    // Error flag follows the state being entered so it is registered and glitch-free.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            boot_err <= 1'b0;
        end else begin
            boot_err <= (state_nxt_s == ST_ERR);
        end
    end
`else
    assign boot_err = 1'b0;
`endif

    // Registered outputs, computed from the state being entered so they align with it.
    // core_reset_n can only rise on a clock edge into RUN and falls asynchronously with reset_n.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ld_ready     <= 1'b0;
            busy         <= 1'b0;
            boot_done    <= 1'b0;
            core_reset_n <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= {ADDR_W{1'b0}};
            imem_wdata   <= {WORD_W{1'b0}};
        end else begin
            ld_ready     <= (state_nxt_s == ST_LOAD);
            busy         <= (state_nxt_s == ST_LOAD) || (state_nxt_s == ST_HOLD);
            boot_done    <= (state_nxt_s == ST_RUN);
            core_reset_n <= (state_nxt_s == ST_RUN);
            imem_we      <= write_s;
            if (write_s) begin
                imem_addr  <= idx_r;
                imem_wdata <= ld_data;
            end
        end
    end

endmodule

// File: tb/tb_riscv_boot_ctrl.sv
// Self-checking bench for riscv_boot_ctrl. A timeline model (words left to accept, expected
// write list, release cycle = last write + hold) predicts every output each cycle; directed
// tests add literal expectations. Works with or without CHECKSUM_EN.
module tb_riscv_boot_ctrl;

    localparam int AW  = 10;
    localparam int WW  = 32;
    localparam int HC  = 4;
    localparam int CAP = 1 << AW;
`ifdef CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW:0]   num_words;
    logic          ld_valid;
    logic          ld_ready;
    logic [WW-1:0] ld_data;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [WW-1:0] imem_wdata;
    logic          core_reset_n;
    logic          busy;
    logic          boot_done;
    logic          boot_err;

    riscv_boot_ctrl #(.ADDR_W(AW), .WORD_W(WW), .HOLD_CYCLES(HC)) dut (
        .clk          (clk),
        .reset_n      (rst_n),
        .start        (start),
        .num_words    (num_words),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_data      (ld_data),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_reset_n (core_reset_n),
        .busy         (busy),
        .boot_done    (boot_done),
        .boot_err     (boot_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_pass  = 0;
    int n_total = 0;

    // Model state
    int            cyc       = 0;
    bit            m_loading = 1'b0;
    int            m_left    = 0;
    int            m_idx     = 0;
    logic [31:0]   m_sum     = 32'h0;
    int            m_release = -1;
    bit            m_run     = 1'b0;
    bit            m_err     = 1'b0;
    bit            m_we      = 1'b0;
    bit            m_acc     = 1'b0;
    logic [AW-1:0] m_addr    = '0;
    logic [31:0]   m_data    = 32'h0;

    // Observations of the DUT
    logic [31:0]   shadow [CAP];
    int            n_writes    = 0;
    int            last_we_cyc = 0;
    int            last_addr   = 0;
    int            rise_cyc    = 0;
    int            ready_cnt   = 0;
    int            start_cyc   = 0;
    bit            prev_core   = 1'b0;
    logic [31:0]   img [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [47:0] dut_vec();
        return {ld_ready, imem_we, busy, boot_done, core_reset_n, boot_err, imem_addr, imem_wdata};
    endfunction

    task automatic model_clear();
        m_loading = 1'b0; m_left = 0; m_idx = 0; m_sum = 32'h0; m_release = -1;
        m_run = 1'b0; m_err = 1'b0; m_we = 1'b0; m_acc = 1'b0; m_addr = '0; m_data = 32'h0;
    endtask

    // Advance the model by one clock edge using the inputs the bench is driving.
    task automatic model_step();
        bit pre_load;
        bit pre_hold;
        int cap;
        pre_load = m_loading;
        pre_hold = (m_release >= 0);
        m_we  = 1'b0;
        m_acc = 1'b0;
        if (!rst_n) begin
            model_clear();
            return;
        end
        if (pre_load && ld_valid) begin
            m_acc = 1'b1;
            if (m_left > 0) begin
                m_we = 1'b1; m_addr = AW'(m_idx); m_data = ld_data;
                m_idx++; m_left--; m_sum = m_sum + ld_data;
                if (m_left == 0 && !CK) begin
                    m_loading = 1'b0; m_release = cyc + HC;
                end
            end else begin
                m_loading = 1'b0;
                if (32'(m_sum + ld_data) == 32'h0) m_release = cyc + HC;
                else m_err = 1'b1;
            end
        end else if (!pre_load && !pre_hold && start) begin
            cap = (num_words > 11'd1024) ? CAP : int'(num_words);
            m_run = 1'b0; m_err = 1'b0; m_idx = 0; m_sum = 32'h0; m_left = cap;
            if (cap == 0 && !CK) m_release = cyc + HC;
            else m_loading = 1'b1;
        end
        if (pre_hold && cyc == m_release) begin
            m_run = 1'b1; m_release = -1;
        end
    endtask

    // One clock: model update on the rising edge, compare and observe on the falling edge.
    task automatic tick();
        logic [47:0] ev;
        bit          e_busy;
        @(posedge clk);
        cyc++;
        model_step();
        @(negedge clk);
        e_busy = m_loading || (m_release >= 0);
        ev = {m_loading, m_we, e_busy, m_run, m_run, m_err, m_addr, m_data};
        check("cycle", 64'(dut_vec()), 64'(ev));
        if (imem_we) begin
            shadow[imem_addr] = imem_wdata;
            n_writes++; last_we_cyc = cyc; last_addr = int'(imem_addr);
        end
        if (core_reset_n && !prev_core) rise_cyc = cyc;
        prev_core = core_reset_n;
        if (ld_ready) ready_cnt++;
    endtask

    task automatic do_start(input int nw);
        start = 1'b1;
        num_words = (AW + 1)'(nw);
        tick();
        start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        int n;
        ld_valid = 1'b1;
        ld_data  = w;
        n = 0;
        do begin
            tick();
            n++;
        end while (!m_acc && n < 64);
        if (!m_acc) check("accept_timeout", 64'(m_acc), 64'd1);
        ld_valid = 1'b0;
        ld_data  = 32'hDEADBEEF;
        if (gap) tick();
    endtask

    task automatic finish_image(input logic [31:0] s);
        if (CK) send_word(32'h0 - s, 1'b0);
    endtask

    task automatic run_load(input int nw, input bit gap);
        int cap;
        logic [31:0] s;
        cap = (nw > CAP) ? CAP : nw;
        s = 32'h0;
        do_start(nw);
        for (int i = 0; i < cap; i++) begin
            send_word(img[i], gap);
            s = s + img[i];
        end
        finish_image(s);
    endtask

    task automatic wait_run();
        int n;
        n = 0;
        while (boot_done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("run_reached", 64'(boot_done), 64'd1);
    endtask

    task automatic clear_obs();
        for (int i = 0; i < CAP; i++) shadow[i] = 32'h0;
        n_writes = 0;
        ready_cnt = 0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; num_words = '0; ld_valid = 1'b0; ld_data = 32'h0;
        clear_obs();
        model_clear();
        tick();
        tick();
        check("reset_state", 64'(dut_vec()), 64'd0);
        rst_n = 1'b1;
        tick();

        // Test 1: three words, no gaps
        img = '{32'h00500093, 32'h00A00113, 32'h002081B3};
        clear_obs();
        run_load(3, 1'b0);
        wait_run();
        check("t1_mem0", 64'(shadow[0]), 64'h00500093);
        check("t1_mem1", 64'(shadow[1]), 64'h00A00113);
        check("t1_mem2", 64'(shadow[2]), 64'h002081B3);
        check("t1_writes", 64'(n_writes), 64'd3);
        check("t1_model_idx", 64'(m_idx), 64'd3);
`ifndef CHECKSUM_EN
        check("t1_release_delay", 64'(rise_cyc - last_we_cyc), 64'd4);
`endif

        // Test 2: same image with ld_valid gaps, start pulse mid-load is ignored
        clear_obs();
        do_start(3);
        send_word(32'h00500093, 1'b1);
        start = 1'b1;
        num_words = 11'd7;
        send_word(32'h00A00113, 1'b1);
        start = 1'b0;
        send_word(32'h002081B3, 1'b1);
        finish_image(32'h00500093 + 32'h00A00113 + 32'h002081B3);
        wait_run();
        check("t2_mem0", 64'(shadow[0]), 64'h00500093);
        check("t2_mem1", 64'(shadow[1]), 64'h00A00113);
        check("t2_mem2", 64'(shadow[2]), 64'h002081B3);
        check("t2_writes", 64'(n_writes), 64'd3);
`ifndef CHECKSUM_EN
        check("t2_ready_cycles", 64'(ready_cnt), 64'd5);
`endif

        // Test 3a: empty image
        clear_obs();
        do_start(0);
        finish_image(32'h0);
        wait_run();
        check("t3_empty_writes", 64'(n_writes), 64'd0);
`ifndef CHECKSUM_EN
        check("t3_empty_hold", 64'(rise_cyc - start_cyc), 64'd4);
`endif

        // Test 4: reload from RUN re-resets the core
        clear_obs();
        do_start(1);
        check("t4_core_low", 64'(core_reset_n), 64'd0);
        check("t4_done_low", 64'(boot_done), 64'd0);
        send_word(32'h00000013, 1'b0);
        finish_image(32'h00000013);
        wait_run();
        check("t4_core_high", 64'(core_reset_n), 64'd1);
        check("t4_mem0", 64'(shadow[0]), 64'h00000013);

        // Test 3b: oversize image saturates at capacity
        img.delete();
        for (int i = 0; i < CAP + 1; i++) img.push_back(32'h10000000 + 32'(i * 3));
        clear_obs();
        run_load(CAP + 1, 1'b0);
        wait_run();
        check("t3_sat_writes", 64'(n_writes), 64'd1024);
        check("t3_sat_last_addr", 64'(last_addr), 64'd1023);
        check("t3_sat_last_word", 64'(shadow[1023]), 64'h10000BFD);
        check("t3_sat_first_word", 64'(shadow[0]), 64'h10000000);

        // Test 5: asynchronous reset in the middle of a load
        clear_obs();
        do_start(5);
        send_word(32'hAAAA0000, 1'b0);
        send_word(32'hAAAA0001, 1'b0);
        #2 rst_n = 1'b0;
        #1 check("t5_async_reset", 64'(dut_vec()), 64'd0);
        model_clear();
        ld_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        img = '{32'hCAFE0001, 32'hCAFE0002};
        clear_obs();
        run_load(2, 1'b0);
        wait_run();
        check("t5_mem0", 64'(shadow[0]), 64'hCAFE0001);
        check("t5_mem1", 64'(shadow[1]), 64'hCAFE0002);
        check("t5_writes", 64'(n_writes), 64'd2);

`ifdef CHECKSUM_EN
        // Test 6: checksum pass and fail
        begin
            int n;
            clear_obs();
            do_start(2);
            send_word(32'd1, 1'b0);
            send_word(32'd2, 1'b0);
            send_word(32'hFFFFFFFD, 1'b0);
            wait_run();
            check("t6_pass_err", 64'(boot_err), 64'd0);
            clear_obs();
            do_start(2);
            send_word(32'd1, 1'b0);
            send_word(32'd2, 1'b0);
            send_word(32'h0, 1'b0);
            n = 0;
            while (boot_err !== 1'b1 && n < 50) begin
                tick();
                n++;
            end
            check("t6_err", 64'(boot_err), 64'd1);
            check("t6_err_core", 64'(core_reset_n), 64'd0);
            check("t6_err_writes", 64'(n_writes), 64'd2);
            repeat (3) tick();
            check("t6_err_sticky", 64'(boot_err), 64'd1);
            do_start(1);
            send_word(32'd5, 1'b0);
            send_word(32'hFFFFFFFB, 1'b0);
            wait_run();
            check("t6_recover_err", 64'(boot_err), 64'd0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
